// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port frame buffer owner on the pixel clock.
// Shares one RAM port between display scan-out (highest priority), an
// optional clear engine, and a handshaked pixel writer. Display data
// reaches pix two cycles after the scan coordinate is presented.
// Optional feature macro: FB_CLEAR_EN builds the clear engine. Without it,
// clr_start is ignored and clr_busy is tied low.
`timescale 1ns/1ps

module fb_arbiter #(
  parameter int                GRID_W    = 160,
  parameter int                GRID_H    = 120,
  parameter int                DATA_W    = 4,
  parameter int                ADDR_W    = 15,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        vgaX,
  input  logic [7:0]        vgaY,
  input  logic              blank_b,
  input  logic              wr_req,
  input  logic [7:0]        wr_x,
  input  logic [7:0]        wr_y,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              wr_drop,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix
);

  localparam logic [ADDR_W-1:0] GRID_W_A = ADDR_W'(GRID_W);
  localparam logic [31:0]       GRID_W_U = 32'(GRID_W);
  localparam logic [31:0]       GRID_H_U = 32'(GRID_H);

  // Linear address of a logical coordinate, wrapped to the RAM width.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [7:0] cx, input logic [7:0] cy);
    return ADDR_W'(cy) * GRID_W_A + ADDR_W'(cx);
  endfunction

  function automatic logic in_range(input logic [7:0] cx, input logic [7:0] cy);
    return (32'(cx) < GRID_W_U) && (32'(cy) < GRID_H_U);
  endfunction

  // ---------------------------------------------------------------------
  // Display read request
  // ---------------------------------------------------------------------
  logic              last_vld_q;
  logic [7:0]        last_x_q;
  logic [7:0]        last_y_q;
  logic              disp_in_range;
  logic              disp_new;
  logic              disp_rd;
  logic              disp_oor;
  logic [ADDR_W-1:0] disp_addr;

  assign disp_in_range = in_range(vgaX, vgaY);
  assign disp_addr     = addr_of(vgaX, vgaY);
  assign disp_new      = !last_vld_q || (vgaX != last_x_q) || (vgaY != last_y_q);
  // Reads are only issued for a fresh in-range coordinate during active video.
  assign disp_rd       = reset && blank_b && disp_in_range && disp_new;
  assign disp_oor      = blank_b && !disp_in_range;

  // ---------------------------------------------------------------------
  // Clear engine
  // ---------------------------------------------------------------------
  logic              clr_active;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef FB_CLEAR_EN
  localparam int                NPIX      = GRID_W * GRID_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } clr_state_e;

  clr_state_e        state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              clr_busy_q;

  assign clr_active = (state_q == S_CLEAR);
  assign clr_we     = clr_active && !disp_rd;
  assign clr_addr   = clr_addr_q;
  assign clr_busy   = clr_busy_q;

  // Clear sequencer: sweeps every pixel once, yielding slots to display reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      clr_addr_q <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clr_start) begin
            state_q    <= S_CLEAR;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (clr_we) begin
            if (clr_addr_q == LAST_ADDR) begin
              state_q    <= S_IDLE;
              clr_busy_q <= 1'b0;
            end else begin
              clr_addr_q <= clr_addr_q + ADDR_W'(1);
            end
          end
        end
        default: begin
          state_q    <= S_IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign clr_active       = 1'b0;
  assign clr_we           = 1'b0;
  assign clr_addr         = '0;
  assign clr_busy         = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Writer grant
  // ---------------------------------------------------------------------
  logic              wr_grant;
  logic              wr_in_range;
  logic [ADDR_W-1:0] wr_addr;

  assign wr_in_range = in_range(wr_x, wr_y);
  assign wr_addr     = addr_of(wr_x, wr_y);
  assign wr_grant    = reset && wr_req && !disp_rd && !clr_active;
  assign wr_ack      = wr_grant;
  assign wr_drop     = wr_grant && !wr_in_range;

  // ---------------------------------------------------------------------
  // RAM port mux
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_hold_q;
  logic [ADDR_W-1:0] addr_hold_d;

  // One access per cycle: display read, then clear write, then writer write.
  always_comb begin
    ram_addr  = addr_hold_q;
    ram_we    = 1'b0;
    ram_wdata = wr_data;
    if (!reset) begin
      ram_addr = '0;
    end else if (disp_rd) begin
      ram_addr = disp_addr;
    end else if (clr_we) begin
      ram_addr  = clr_addr;
      ram_we    = 1'b1;
      ram_wdata = CLEAR_VAL;
    end else if (wr_grant && wr_in_range) begin
      ram_addr = wr_addr;
      ram_we   = 1'b1;
    end
  end

  assign addr_hold_d = ram_addr;

  // Keeps the address bus stable on idle cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hold_q <= '0;
    end else begin
      addr_hold_q <= addr_hold_d;
    end
  end

  // ---------------------------------------------------------------------
  // Last-read tracking
  // ---------------------------------------------------------------------
  // Blanking or an off-grid coordinate forces the next valid pixel to re-read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_vld_q <= 1'b0;
      last_x_q   <= '0;
      last_y_q   <= '0;
    end else if (!blank_b || disp_oor) begin
      last_vld_q <= 1'b0;
    end else if (disp_rd) begin
      last_vld_q <= 1'b1;
      last_x_q   <= vgaX;
      last_y_q   <= vgaY;
    end
  end

  // ---------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------
  logic              rd_q;
  logic              oor_q;
  logic              blank_d1_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;
  logic [DATA_W-1:0] pix_q;

  // Fresh RAM data lands in the hold path the cycle after its read, an
  // off-grid coordinate forces black, otherwise the last pixel is replicated.
  always_comb begin
    hold_d = hold_q;
    if (rd_q) begin
      hold_d = ram_rdata;
    end else if (oor_q) begin
      hold_d = '0;
    end
  end

  // Registers the pixel once more and blanks it in step with the video timing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q       <= 1'b0;
      oor_q      <= 1'b0;
      blank_d1_q <= 1'b0;
      hold_q     <= '0;
      pix_q      <= '0;
    end else begin
      rd_q       <= disp_rd;
      oor_q      <= disp_oor;
      blank_d1_q <= blank_b;
      hold_q     <= hold_d;
      pix_q      <= blank_d1_q ? hold_d : '0;
    end
  end

  assign pix = pix_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: self-checking bench for fb_arbiter with a behavioural
// synchronous RAM, a shadow image of expected buffer contents, and a
// queue-based scoreboard for the two-cycle display pipeline.
// Clear-engine scenarios are exercised when FB_CLEAR_EN is defined.
`timescale 1ns/1ps

module tb_fb_arbiter;

  localparam int          GRID_W = 160;
  localparam int          GRID_H = 120;
  localparam int          DATA_W = 4;
  localparam int          ADDR_W = 15;
  localparam int          NPIX   = GRID_W * GRID_H;
  localparam logic [3:0]  CLR_V  = 4'h0;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        vgaX, vgaY;
  logic              blank_b;
  logic              wr_req;
  logic [7:0]        wr_x, wr_y;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack, wr_drop;
  logic              clr_start;
  logic              clr_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] pix;

  always #5 clk = ~clk;

  fb_arbiter #(
    .GRID_W   (GRID_W),
    .GRID_H   (GRID_H),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .CLEAR_VAL(CLR_V)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vgaX     (vgaX),
    .vgaY     (vgaY),
    .blank_b  (blank_b),
    .wr_req   (wr_req),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .wr_drop  (wr_drop),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .pix      (pix)
  );

  // Behavioural single-port RAM, read data one cycle after the address.
  logic [3:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Expected buffer contents, maintained only from what the bench drives.
  logic [3:0] shadow [0:NPIX-1];

  function automatic logic [3:0] pattern(input int a);
    return (a == 0) ? 4'h5 : 4'((a * 7 + 3) & 15);
  endfunction

  function automatic bit tb_in_rng(input int x, input int y);
    return (x < GRID_W) && (y < GRID_H);
  endfunction

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      if (n_errors <= 100)
        $display("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: expected pix for the inputs of each cycle, compared two cycles later.
  int exp_q[$];
  bit sb_en = 1'b0;
  always @(negedge clk) begin
    int e;
    if (sb_en) begin
      e = 0;
      if (blank_b && tb_in_rng(int'(vgaX), int'(vgaY)))
        e = int'(shadow[int'(vgaY) * GRID_W + int'(vgaX)]);
      exp_q.push_back(e);
      if (exp_q.size() > 2) chk("pix", 32'(pix), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_set(input int x, input int y, input logic [3:0] d);
    wr_req  = 1'b1;
    wr_x    = 8'(x);
    wr_y    = 8'(y);
    wr_data = d;
    $display("txn write x=%0d y=%0d data=%0h", x, y, d);
  endtask

  task automatic disp(input int x, input int y, input bit b, input int hold);
    vgaX    = 8'(x);
    vgaY    = 8'(y);
    blank_b = b;
    $display("txn display x=%0d y=%0d blank_b=%0d cycles=%0d", x, y, b, hold);
    repeat (hold) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    reset = 1'b0; vgaX = '0; vgaY = '0; blank_b = 1'b0;
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0; clr_start = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= pattern(i);
    for (int i = 0; i < NPIX; i++) shadow[i] = pattern(i);

    // Reset state, with a request pending to show outputs are held off.
    wr_set(3, 2, 4'hA);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 32'(wr_ack), 0);
    chk("rst_drop", 32'(wr_drop), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_addr", 32'(ram_addr), 0);
    chk("rst_busy", 32'(clr_busy), 0);
    chk("rst_pix", 32'(pix), 0);
    wr_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb_en = 1'b1;
    @(negedge clk);
    chk("idle_addr", 32'(ram_addr), 0);
    chk("idle_we", 32'(ram_we), 0);
    tick();

    // Writer during blanking.
    wr_set(3, 2, 4'hA);
    @(negedge clk);
    chk("wr_ack", 32'(wr_ack), 1);
    chk("wr_we", 32'(ram_we), 1);
    chk("wr_addr", 32'(ram_addr), 323);
    chk("wr_wdata", 32'(ram_wdata), 32'hA);
    chk("wr_drop", 32'(wr_drop), 0);
    shadow[323] = 4'hA;
    tick();

    // Out-of-range writes: acked and dropped, bus address held.
    wr_set(160, 0, 4'hF);
    @(negedge clk);
    chk("oorx_ack", 32'(wr_ack), 1);
    chk("oorx_drop", 32'(wr_drop), 1);
    chk("oorx_we", 32'(ram_we), 0);
    chk("oorx_addr", 32'(ram_addr), 323);
    tick();
    wr_set(0, 120, 4'hF);
    @(negedge clk);
    chk("oory_drop", 32'(wr_drop), 1);
    chk("oory_we", 32'(ram_we), 0);
    tick();
    wr_req = 1'b0;

    // Display read of (0,0).
    vgaX = 8'd0; vgaY = 8'd0; blank_b = 1'b1;
    @(negedge clk);
    chk("rd_addr", 32'(ram_addr), 0);
    chk("rd_we", 32'(ram_we), 0);
    repeat (4) tick();
    @(negedge clk);
    chk("rd_pix_hold", 32'(pix), 32'h5);
    tick();

    // Collision: coordinate change and write request together.
    vgaX = 8'd1;
    wr_set(10, 10, 4'h7);
    @(negedge clk);
    chk("col_ack0", 32'(wr_ack), 0);
    chk("col_rdaddr", 32'(ram_addr), 1);
    chk("col_we0", 32'(ram_we), 0);
    tick();
    @(negedge clk);
    chk("col_ack1", 32'(wr_ack), 1);
    chk("col_wraddr", 32'(ram_addr), 1610);
    chk("col_we1", 32'(ram_we), 1);
    shadow[1610] = 4'h7;
    tick();
    wr_req = 1'b0;
    repeat (3) tick();

    // Out-of-range display coordinates, then return to a cached coordinate.
    disp(200, 0, 1'b1, 3);
    disp(5, 130, 1'b1, 3);
    disp(0, 0, 1'b1, 3);
    disp(0, 0, 1'b0, 3);
    disp(0, 0, 1'b1, 3);
    disp(10, 10, 1'b1, 3);

    // Randomised scan patterns.
    for (int i = 0; i < 60; i++)
      disp(int'($urandom_range(170, 0)), int'($urandom_range(125, 0)),
           ($urandom_range(7, 0) != 0), int'($urandom_range(3, 1)));
    disp(0, 0, 1'b0, 3);

    // clr_start together with a write request: the writer wins this cycle.
    wr_set(5, 5, 4'h9);
    clr_start = 1'b1;
    @(negedge clk);
    chk("cs_ack", 32'(wr_ack), 1);
    chk("cs_we", 32'(ram_we), 1);
    chk("cs_addr", 32'(ram_addr), 805);
    chk("cs_busy", 32'(clr_busy), 0);
    shadow[805] = 4'h9;
    tick();
    clr_start = 1'b0;
    wr_set(7, 7, 4'h3);
`ifdef FB_CLEAR_EN
    $display("txn clear start");
    for (int a = 0; a < NPIX; a++) begin
      @(negedge clk);
      chk("clr_we", 32'(ram_we), 1);
      chk("clr_addr", 32'(ram_addr), 32'(a));
      chk("clr_data", 32'(ram_wdata), 32'(CLR_V));
      chk("clr_busy", 32'(clr_busy), 1);
      chk("clr_noack", 32'(wr_ack), 0);
      tick();
      clr_start = (a == 4999);
    end
    for (int i = 0; i < NPIX; i++) shadow[i] = CLR_V;
    $display("txn clear done");
`endif
    @(negedge clk);
    chk("post_busy", 32'(clr_busy), 0);
    chk("post_ack", 32'(wr_ack), 1);
    chk("post_addr", 32'(ram_addr), 1127);
    chk("post_we", 32'(ram_we), 1);
    shadow[1127] = 4'h3;
    tick();
    wr_req = 1'b0;

    // Contents after the clear (or unchanged without the clear engine).
    disp(5, 5, 1'b1, 3);
    disp(7, 7, 1'b1, 3);
    disp(3, 2, 1'b1, 3);
    disp(0, 0, 1'b1, 3);
    disp(0, 0, 1'b0, 3);

    // Put a known non-zero pixel on pix before the reset test.
    wr_set(3, 2, 4'hA);
    @(negedge clk);
    chk("pre_ack", 32'(wr_ack), 1);
    shadow[323] = 4'hA;
    tick();
    wr_req = 1'b0;
    disp(3, 2, 1'b1, 4);
    @(negedge clk);
    chk("pre_pix", 32'(pix), 32'hA);
    tick();
    sb_en = 1'b0;
    exp_q.delete();

    // Reset asserted mid-operation.
    wr_set(9, 9, 4'h1);
`ifdef FB_CLEAR_EN
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 1'b0;
    for (int g = 0; g < 400; g++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 15'd100) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("clr_reach100", 32'(found), 1);
`else
    @(negedge clk);
`endif
    #2 reset = 1'b0;
    #1;
    chk("ar_pix", 32'(pix), 0);
    chk("ar_ack", 32'(wr_ack), 0);
    chk("ar_drop", 32'(wr_drop), 0);
    chk("ar_busy", 32'(clr_busy), 0);
    chk("ar_we", 32'(ram_we), 0);
    chk("ar_addr", 32'(ram_addr), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ar_hold_addr", 32'(ram_addr), 0);
    chk("ar_hold_busy", 32'(clr_busy), 0);
    @(posedge clk); #1;
    reset   = 1'b1;
    blank_b = 1'b0;
    @(negedge clk);
    chk("rel_ack", 32'(wr_ack), 1);
    chk("rel_busy", 32'(clr_busy), 0);
    chk("rel_addr", 32'(ram_addr), 1449);
    tick();
    wr_req = 1'b0;
    @(negedge clk);
    chk("rel_pix", 32'(pix), 0);
    chk("rel_busy2", 32'(clr_busy), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
# fb_arbiter

Owns the single-port pixel frame buffer RAM on the VGA pixel clock domain and shares it between display scan-out and a pixel writer. Display reads always win, and the writer gets the remaining slots. An optional clear engine can sweep the whole buffer to a constant value. The block sits between the VGA timing generator (which supplies `vgaX`, `vgaY` and `blank_b`), the drawing/update logic (the writer) and the RAM macro.

## Interface
- `GRID_W`, 160: logical pixels per row.
- `GRID_H`, 120: logical rows.
- `DATA_W`, 4: bits per stored pixel.
- `ADDR_W`, 15: RAM address width. Must satisfy 2^ADDR_W ≥ GRID_W*GRID_H.
- `CLEAR_VAL`, 0: value written by the clear engine.

Ports:
- `clk` input 1: pixel clock (`vgaclk`). All logic on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `vgaX`, `vgaY` input 8 each: logical scan coordinate from the timing generator.
- `blank_b` input 1: high during active video.
- `wr_req` input 1: writer request. Held until `wr_ack`.
- `wr_x`, `wr_y` input 8 each: write coordinate.
- `wr_data` input DATA_W: write pixel.
- `wr_ack` output 1: one-cycle grant pulse.
- `wr_drop` output 1: pulses with `wr_ack` when the write coordinate was out of range.
- `clr_start` input 1: pulse that starts a clear.
- `clr_busy` output 1: high while the clear engine is active.
- `ram_addr` output ADDR_W: RAM address.
- `ram_we` output 1: RAM write enable.
- `ram_wdata` output DATA_W: RAM write data.
- `ram_rdata` input DATA_W: RAM read data, synchronous, valid 1 cycle after the address.
- `pix` output DATA_W: registered pixel to the DAC path.

## Operation
- **Address:** addr = y*GRID_W + x, computed at ADDR_W width. Coordinates are in range iff x < GRID_W and y < GRID_H.
- **Slot arbitration:** one RAM access per cycle. Priority, highest first: display read, clear write, writer write.
- **Display read:**
  - A read is issued when `blank_b`=1, the coordinate is in range, and (`vgaX`,`vgaY`) differs from the last-read coordinate, or the last-read register is invalid.
  - The last-read register is invalidated on reset and whenever `blank_b`=0.
  - Out-of-range display coordinates issue no read and force the captured pixel to 0.
- **Pixel output:**
  - `ram_rdata` is captured into a hold register the cycle after a display read.
  - `pix` = the hold register registered once more, gated to 0 when the delayed `blank_b` is 0.
  - Between reads, `pix` holds its value, so each logical pixel is replicated across the physical pixels that map to it.
- **Writer:**
  - In a cycle with no display read, no clear, and `wr_req`=1, `wr_ack`=1 is asserted combinationally.
  - `ram_we`=1 only if the coordinate is in range. Otherwise `wr_drop`=1 and no RAM write occurs.
  - The writer must drop `wr_req` or present the next request after seeing `wr_ack`.
- **Clear FSM states:**
  - IDLE → CLEAR on `clr_start`. `clr_addr` is reset to 0.
  - In CLEAR, each non-display cycle writes `CLEAR_VAL` to `clr_addr` and then increments it.
  - The write at GRID_W*GRID_H-1 returns the FSM to IDLE.
  - `clr_start` while in CLEAR is ignored.
  - The writer is never acked while in CLEAR.
- **Idle RAM signals:** `ram_addr` holds its last value and `ram_we`=0.

## Timing
- **Reset values:** `pix`=0, `wr_ack`=0, `wr_drop`=0, `clr_busy`=0, `ram_we`=0, `ram_addr`=0. FSM in IDLE, last-read register invalid, hold register 0.
- **Display latency:** coordinate change to `pix` update is exactly 2 cycles. The timing generator's `vgaX`/`vgaY`/`blank_b` therefore lead the `hsync`/`vsync` they accompany by 2 cycles.
- **`clr_busy`:** rises the cycle after `clr_start` and falls the cycle after the final clear write.
- A full clear takes GRID_W*GRID_H plus the number of display-read cycles during the sweep.
- **Simultaneous events:**
  - Coordinate change plus `wr_req` in the same cycle: the display read wins and `wr_ack`=0.
  - `clr_start` plus `wr_req` in the same cycle: the writer is acked this cycle and the clear begins next cycle.
- **Reset mid-clear:** aborts immediately. The buffer may be partially cleared.

## Configuration
- `FB_CLEAR_EN` defined: the clear engine and its FSM are built as described.
- Undefined: `clr_start` is ignored, `clr_busy` is tied to 0, and arbitration is display then writer only.

## Test plan
- **Writer, blanking:** with `blank_b`=0, `wr_req` at (3,2) with data 0xA → `wr_ack` the same cycle, `ram_we`=1, `ram_addr`=323, `ram_wdata`=0xA.
- **Display read:** RAM holds 0x5 at addr 0. `blank_b`=1 and (0,0) is presented → read at `ram_addr`=0, and `pix`=0x5 two cycles later, held while the coordinate is stable.
- **Collision:** coordinate changes in the same cycle as `wr_req` → no ack that cycle, ack in the next free cycle, no display read lost.
- **Out of range:** `wr_x`=160 → `wr_ack`=1, `wr_drop`=1, `ram_we`=0. Display coordinate (200,0) → `pix`=0.
- **Clear (`FB_CLEAR_EN`):** `clr_start` during blanking → 19200 consecutive writes of `CLEAR_VAL` at addresses 0..19199. `clr_busy` falls 1 cycle after the last write, and `wr_req` stays unacked until then.
- **Reset mid-clear:** assert `reset` low at address 100 → all outputs return to reset values asynchronously, and FSM is IDLE after release.
